// File: rtl/mmu_pkg.sv
// Shared state type, default width and saturating-add helper for the mmu tile sequencer.
// sat_add is only referenced when MMU_SEQ_SAT_EN is defined.
package mmu_pkg;

    localparam int unsigned ACC_W_DEF = 32;
    localparam int unsigned SAT_W     = 64;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitLd,
        StSwap,
        StMult,
        StWaitRes,
        StOut
    } mmu_seq_state_e;

    // Operands are w-bit values sign-extended into SAT_W bits; result MSB flags clamping.
    function automatic logic [SAT_W:0] sat_add(input logic signed [SAT_W-1:0] a,
                                               input logic signed [SAT_W-1:0] b,
                                               input int unsigned w);
        logic signed [SAT_W:0] sum;
        logic signed [SAT_W:0] hi;
        logic signed [SAT_W:0] lo;
        sum = {a[SAT_W-1], a} + {b[SAT_W-1], b};
        hi  = ({{SAT_W{1'b0}}, 1'b1} << (w - 1)) - {{SAT_W{1'b0}}, 1'b1};
        lo  = ~hi;
        if (sum > hi) begin
            sat_add = {1'b1, hi[SAT_W-1:0]};
        end else if (sum < lo) begin
            sat_add = {1'b1, lo[SAT_W-1:0]};
        end else begin
            sat_add = {1'b0, sum[SAT_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/mmu_acc_bank.sv
// SIZE x SIZE partial-sum register array: clear, load or add the incoming mmu tile.
// With MMU_SEQ_SAT_EN each element saturates and sat_o reports it; otherwise elements wrap.
module mmu_acc_bank
    import mmu_pkg::*;
#(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic                       ld_i,
    input  logic                       add_i,
    input  logic [ACC_W*SIZE*SIZE-1:0] din_i,
    output logic [ACC_W*SIZE*SIZE-1:0] acc_o,
    output logic                       sat_o
);

    localparam int unsigned N = SIZE * SIZE;

    logic [ACC_W*N-1:0] acc_q;
    logic [ACC_W*N-1:0] acc_d;
    logic [ACC_W*N-1:0] sum;
    logic [N-1:0]       sat_vec;

    for (genvar i = 0; i < N; i++) begin : g_elem
        logic [ACC_W-1:0] a;
        logic [ACC_W-1:0] b;
        assign a = acc_q[i*ACC_W +: ACC_W];
        assign b = din_i[i*ACC_W +: ACC_W];
`ifdef MMU_SEQ_SAT_EN
        logic [SAT_W:0] r;
        assign r = sat_add(SAT_W'($signed(a)), SAT_W'($signed(b)), ACC_W);
        assign sum[i*ACC_W +: ACC_W] = r[ACC_W-1:0];
        assign sat_vec[i] = r[SAT_W];
`else
        assign sum[i*ACC_W +: ACC_W] = a + b;
        assign sat_vec[i] = 1'b0;
`endif
    end

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (add_i) begin
            acc_d = sum;
        end else if (ld_i) begin
            acc_d = din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
    assign sat_o = add_i & (|sat_vec);

endmodule

// File: rtl/mmu_tile_seq.sv
// K-tiled sequencer in front of an mmu: load/swap/mult/pop per tile, optional accumulation.
// Saturating accumulation is enabled by defining MMU_SEQ_SAT_EN.
module mmu_tile_seq
    import mmu_pkg::*;
#(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned MAX_K = 16,
    parameter int unsigned KW    = $clog2(MAX_K + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_rdy,
    input  logic [KW-1:0]              cmd_k,
    input  logic                       cmd_accum,
    input  logic                       weight_ld_rdy,
    output logic                       weight_ld_start,
    input  logic                       weight_ld_done,
    output logic                       weight_swap,
    input  logic                       mult_rdy,
    output logic                       mult_start,
    input  logic                       mult_done,
    input  logic [ACC_W*SIZE*SIZE-1:0] acc_out,
    input  logic                       acc_out_rdy,
    output logic                       acc_out_pop,
    output logic [ACC_W*SIZE*SIZE-1:0] res_out,
    output logic                       res_valid,
    input  logic                       res_rdy,
    output logic                       busy,
    output logic                       err
);

    mmu_seq_state_e state_q, state_d;
    logic [KW-1:0]  k_rem_q, k_rem_d;
    logic           accum_q, accum_d;
    logic           err_q, err_d;
    logic           ld_start_q, ld_start_d;
    logic           swap_q, swap_d;
    logic           mult_start_q, mult_start_d;
    logic           pop_q, pop_d;
    logic           cmd_rdy_q, cmd_rdy_d;
    logic           busy_q, busy_d;
    logic           res_valid_q, res_valid_d;

    logic accept, cmd_bad, take;
    logic acc_clr, acc_ld, acc_add, acc_sat;

    assign accept  = cmd_valid && cmd_rdy_q;
    assign cmd_bad = (cmd_k == '0) || (cmd_k > KW'(MAX_K));
    assign take    = (state_q == StWaitRes) && acc_out_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            k_rem_q      <= '0;
            accum_q      <= 1'b0;
            err_q        <= 1'b0;
            ld_start_q   <= 1'b0;
            swap_q       <= 1'b0;
            mult_start_q <= 1'b0;
            pop_q        <= 1'b0;
            cmd_rdy_q    <= 1'b0;
            busy_q       <= 1'b0;
            res_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_rem_q      <= k_rem_d;
            accum_q      <= accum_d;
            err_q        <= err_d;
            ld_start_q   <= ld_start_d;
            swap_q       <= swap_d;
            mult_start_q <= mult_start_d;
            pop_q        <= pop_d;
            cmd_rdy_q    <= cmd_rdy_d;
            busy_q       <= busy_d;
            res_valid_q  <= res_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept && !cmd_bad) state_d = StLoad;
            StLoad:    if (weight_ld_rdy) state_d = StWaitLd;
            StWaitLd:  if (weight_ld_done) state_d = StSwap;
            StSwap:    state_d = StMult;
            StMult:    if (mult_rdy) state_d = StWaitRes;
            StWaitRes: begin
                if (acc_out_rdy) begin
                    state_d = (accum_q && (k_rem_q > KW'(1))) ? StLoad : StOut;
                end
            end
            StOut:     if (res_rdy) state_d = (k_rem_q == '0) ? StIdle : StLoad;
            default:   state_d = StIdle;
        endcase
    end

    // Datapath: command latch, tile countdown, accumulator controls and sticky error.
    always_comb begin
        k_rem_d = k_rem_q;
        accum_d = accum_q;
        err_d   = err_q;
        acc_clr = 1'b0;
        acc_ld  = 1'b0;
        acc_add = 1'b0;
        if ((state_q == StIdle) && accept) begin
            err_d = cmd_bad;
            if (!cmd_bad) begin
                k_rem_d = cmd_k;
                accum_d = cmd_accum;
                acc_clr = 1'b1;
            end
        end
        if (take) begin
            k_rem_d = k_rem_q - KW'(1);
            acc_add = accum_q;
            acc_ld  = !accum_q;
        end
        if (acc_sat) begin
            err_d = 1'b1;
        end
    end

    // Outputs are registered so every pulse is a clean one-cycle flop output.
    always_comb begin
        ld_start_d   = (state_q == StLoad) && weight_ld_rdy;
        swap_d       = (state_q == StSwap);
        mult_start_d = (state_q == StMult) && mult_rdy;
        pop_d        = take;
        cmd_rdy_d    = (state_d == StIdle);
        busy_d       = (state_d != StIdle);
        res_valid_d  = (state_d == StOut);
    end

    mmu_acc_bank #(
        .SIZE  (SIZE),
        .ACC_W (ACC_W)
    ) u_acc_bank (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (acc_clr),
        .ld_i  (acc_ld),
        .add_i (acc_add),
        .din_i (acc_out),
        .acc_o (res_out),
        .sat_o (acc_sat)
    );

    assign cmd_rdy         = cmd_rdy_q;
    assign busy            = busy_q;
    assign res_valid       = res_valid_q;
    assign err             = err_q;
    assign weight_ld_start = ld_start_q;
    assign weight_swap     = swap_q;
    assign mult_start      = mult_start_q;
    assign acc_out_pop     = pop_q;

    // mult_done is informational; a completion with nothing in flight points at a broken mmu.
    assert property (@(posedge clk) disable iff (rst) !(mult_done && (state_q == StIdle)));

endmodule

// File: tb/tb_mmu_tile_seq.sv
// Scoreboard bench for mmu_tile_seq with a behavioural mmu stand-in.
module tb_mmu_tile_seq;

    localparam int unsigned SIZE  = 2;
    localparam int unsigned ACC_W = 32;
    localparam int unsigned MAX_K = 4;
    localparam int unsigned KW    = $clog2(MAX_K + 1);
    localparam int unsigned N     = SIZE * SIZE;
    localparam int unsigned W     = ACC_W * N;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_rdy, cmd_accum;
    logic [KW-1:0] cmd_k;
    logic          weight_ld_rdy, weight_ld_start, weight_swap;
    logic          weight_ld_done = 1'b0;
    logic          mult_rdy, mult_start, mult_done;
    logic [W-1:0]  acc_out = '0;
    logic          acc_out_rdy = 1'b0;
    logic          acc_out_pop;
    logic [W-1:0]  res_out;
    logic          res_valid, res_rdy, busy, err;

    int n_cmp = 0;
    int n_mis = 0;
    int ld_cnt = 0, sw_cnt = 0, mu_cnt = 0, pop_cnt = 0, busy_cyc = 0;
    bit hold_res;
    logic [W-1:0] tile_q[$];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] fifo[$];

    always #5 clk = ~clk;

    mmu_tile_seq #(
        .SIZE  (SIZE),
        .ACC_W (ACC_W),
        .MAX_K (MAX_K),
        .KW    (KW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_rdy         (cmd_rdy),
        .cmd_k           (cmd_k),
        .cmd_accum       (cmd_accum),
        .weight_ld_rdy   (weight_ld_rdy),
        .weight_ld_start (weight_ld_start),
        .weight_ld_done  (weight_ld_done),
        .weight_swap     (weight_swap),
        .mult_rdy        (mult_rdy),
        .mult_start      (mult_start),
        .mult_done       (mult_done),
        .acc_out         (acc_out),
        .acc_out_rdy     (acc_out_rdy),
        .acc_out_pop     (acc_out_pop),
        .res_out         (res_out),
        .res_valid       (res_valid),
        .res_rdy         (res_rdy),
        .busy            (busy),
        .err             (err)
    );

    function automatic logic [W-1:0] fill(input logic [ACC_W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < N; i++) r[i*ACC_W +: ACC_W] = v;
        return r;
    endfunction

    function automatic logic [W-1:0] mk(input logic [ACC_W-1:0] e0, input logic [ACC_W-1:0] e1,
                                        input logic [ACC_W-1:0] e2, input logic [ACC_W-1:0] e3);
        return {e3, e2, e1, e0};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // mmu stand-in: done follows load start, mult_start queues the next tile, pop drops the head.
    always @(negedge clk) begin
        if (weight_ld_start) ld_cnt++;
        if (weight_swap)     sw_cnt++;
        if (mult_start)      mu_cnt++;
        if (acc_out_pop)     pop_cnt++;
        if (busy)            busy_cyc++;
        if (rst) begin
            fifo.delete();
            weight_ld_done = 1'b0;
        end else begin
            weight_ld_done = weight_ld_start;
            if (acc_out_pop && fifo.size() > 0) void'(fifo.pop_front());
            if (mult_start && !hold_res && tile_q.size() > 0) fifo.push_back(tile_q.pop_front());
        end
        acc_out_rdy = (fifo.size() > 0);
        acc_out     = acc_out_rdy ? fifo[0] : '0;
    end

    // Monitor: every presented result is checked against the scoreboard head.
    always @(negedge clk) begin
        #1;
        if (!rst && res_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_result: got %h expected none", res_out);
            end else begin
                check("res_out", res_out, exp_q[0]);
                if (res_rdy) void'(exp_q.pop_front());
            end
        end
    end

    task automatic issue(input int k, input bit acc);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_k     = KW'(k);
        cmd_accum = acc;
        while (!cmd_rdy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_rdy) begin
            n_cmp++;
            n_mis++;
            $display("FAIL cmd_accept_timeout: got cmd_rdy=0 expected 1");
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (busy || exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL done_timeout: got busy=%0d pending=%0d expected 0/0", busy, exp_q.size());
        end
    endtask

    initial begin
        int b0, l0, s0, m0, p0, t;
        logic sat_exp;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_k = '0;
        cmd_accum = 1'b0;
        weight_ld_rdy = 1'b1;
        mult_rdy = 1'b1;
        mult_done = 1'b0;
        res_rdy = 1'b1;
        hold_res = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", {cmd_rdy, busy, res_valid, err, weight_ld_start, weight_swap,
                              mult_start, acc_out_pop}, '0);
        check("rst_res_out", res_out, '0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_rdy_after_rst", cmd_rdy, 1);

        // Non-accum single tile: 6 busy cycles with everything ready
        tile_q.push_back(fill(32'd5));
        exp_q.push_back(fill(32'd5));
        b0 = busy_cyc;
        issue(1, 1'b0);
        wait_done();
        check("busy_cycles_k1", busy_cyc - b0, 6);
        check("cmd_rdy_k1", cmd_rdy, 1);
        check("err_k1", err, 0);

        // Accum over three tiles
        tile_q.push_back(fill(32'd1));
        tile_q.push_back(fill(32'd2));
        tile_q.push_back(fill(32'd3));
        exp_q.push_back(fill(32'd6));
        l0 = ld_cnt; s0 = sw_cnt; m0 = mu_cnt; p0 = pop_cnt;
        issue(3, 1'b1);
        wait_done();
        check("ld_start_cnt_k3", ld_cnt - l0, 3);
        check("swap_cnt_k3", sw_cnt - s0, 3);
        check("mult_start_cnt_k3", mu_cnt - m0, 3);
        check("pop_cnt_k3", pop_cnt - p0, 3);

        // Non-accum two tiles with consumer stalling the first result
        res_rdy = 1'b0;
        tile_q.push_back(fill(32'd7));
        tile_q.push_back(mk(32'd100, 32'd101, 32'd102, 32'd103));
        exp_q.push_back(fill(32'd7));
        exp_q.push_back(mk(32'd100, 32'd101, 32'd102, 32'd103));
        l0 = ld_cnt;
        issue(2, 1'b0);
        t = 0;
        while (!res_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("res_valid_stall", res_valid, 1);
        repeat (10) @(negedge clk);
        check("ld_while_stalled", ld_cnt - l0, 1);
        res_rdy = 1'b1;
        wait_done();
        check("ld_after_handshake", ld_cnt - l0, 2);

        // Zero-length and oversized commands are refused with err
        l0 = ld_cnt; s0 = sw_cnt; m0 = mu_cnt; p0 = pop_cnt;
        issue(0, 1'b0);
        repeat (3) @(negedge clk);
        check("err_k0", err, 1);
        check("busy_k0", busy, 0);
        check("cmd_rdy_k0", cmd_rdy, 1);
        issue(MAX_K + 1, 1'b1);
        repeat (3) @(negedge clk);
        check("err_k_over", err, 1);
        check("pulses_refused", (ld_cnt - l0) + (sw_cnt - s0) + (mu_cnt - m0) + (pop_cnt - p0), 0);

        // MAX_K accumulate, also clears err on accept
        tile_q.push_back(fill(32'd1));
        tile_q.push_back(fill(32'hFFFF_FFFE));
        tile_q.push_back(fill(32'd3));
        tile_q.push_back(fill(32'd10));
        exp_q.push_back(fill(32'd12));
        issue(MAX_K, 1'b1);
        check("err_cleared", err, 0);
        wait_done();
        check("err_maxk", err, 0);

        // Overflow at both ends of the signed range
        tile_q.push_back(mk(32'h7FFF_FFF0, 32'h8000_0010, 32'd1, 32'd0));
        tile_q.push_back(mk(32'h0000_0020, 32'hFFFF_FFE0, 32'd2, 32'hFFFF_FFFF));
`ifdef MMU_SEQ_SAT_EN
        exp_q.push_back(mk(32'h7FFF_FFFF, 32'h8000_0000, 32'd3, 32'hFFFF_FFFF));
        sat_exp = 1'b1;
`else
        exp_q.push_back(mk(32'h8000_0010, 32'h7FFF_FFF0, 32'd3, 32'hFFFF_FFFF));
        sat_exp = 1'b0;
`endif
        issue(2, 1'b1);
        wait_done();
        check("err_overflow", err, sat_exp);

        // Reset while waiting for a result, then a clean command
        hold_res = 1'b1;
        tile_q.push_back(fill(32'd4));
        tile_q.push_back(fill(32'd4));
        m0 = mu_cnt;
        issue(2, 1'b1);
        t = 0;
        while (mu_cnt == m0 && t < 100) begin
            @(negedge clk);
            #2;
            t++;
        end
        check("busy_in_wait_res", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_outputs", {cmd_rdy, busy, res_valid, err, weight_ld_start, weight_swap,
                                  mult_start, acc_out_pop}, '0);
        check("mid_rst_res_out", res_out, '0);
        @(negedge clk);
        #2;
        tile_q.delete();
        hold_res = 1'b0;
        rst = 1'b0;
        tile_q.push_back(fill(32'd9));
        exp_q.push_back(fill(32'd9));
        issue(1, 1'b0);
        wait_done();
        check("err_after_rst", err, 0);
        check("cmd_rdy_after_rst_cmd", cmd_rdy, 1);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/mmu_tile_seq.md
# mmu_tile_seq

Parametrised tile sequencer and partial-sum accumulator that sits directly in front of an `mmu` instance of any `SIZE`. It runs a K-tiled matrix product from a single command, replacing software-driven per-tile sequencing of the weight/mult/result handshakes:
- loads weights for each tile;
- swaps them into the array;
- starts the multiply and pops the result;
- in accumulate mode, sums the K partial results into one output before presenting it downstream.

## Interface
Parameters:
- `SIZE`, 8, array dimension; must match the driven `mmu`.
- `ACC_W`, 32, result/accumulator width, signed two's complement.
- `MAX_K`, 16, maximum tiles per command; `KW = $clog2(MAX_K+1)`.

Ports (one clock `clk`; reset `rst` is asynchronous, active-high):
- `clk` in 1 — clock.
- `rst` in 1 — async active-high reset.
- `cmd_valid` in 1 — command offered.
- `cmd_rdy` out 1 — command accepted when both high.
- `cmd_k` in KW — tile count.
- `cmd_accum` in 1 — 1 = sum tiles into one result; 0 = emit each tile.
- `weight_ld_rdy` in 1 — from mmu.
- `weight_ld_start` out 1 — to mmu.
- `weight_ld_done` in 1 — from mmu.
- `weight_swap` out 1 — to mmu.
- `mult_rdy` in 1 — from mmu.
- `mult_start` out 1 — to mmu.
- `mult_done` in 1 — from mmu; status only.
- `acc_out` in ACC_W×SIZE×SIZE — mmu result FIFO head.
- `acc_out_rdy` in 1 — result FIFO non-empty.
- `acc_out_pop` out 1 — pop result FIFO.
- `res_out` out ACC_W×SIZE×SIZE — result to consumer.
- `res_valid` out 1 — result available.
- `res_rdy` in 1 — consumer takes result.
- `busy` out 1 — high whenever state ≠ IDLE.
- `err` out 1 — sticky: zero-length command or saturation; cleared on next accepted command.

## Operation
- FSM states: IDLE, LOAD, WAIT_LD, SWAP, MULT, WAIT_RES, OUT.
- **IDLE:**
  - `cmd_rdy`=1.
  - On accept: latch `cmd_k` into `k_rem`, latch `cmd_accum`, clear accumulators and `err`, go to LOAD.
  - If `cmd_k`=0: set `err`, stay IDLE; no mmu activity and no result.
- **LOAD:** when `weight_ld_rdy`=1, pulse `weight_ld_start` for one cycle and go to WAIT_LD.
- **WAIT_LD:** on `weight_ld_done`, go to SWAP.
- **SWAP:** pulse `weight_swap` for one cycle, then go to MULT.
- **MULT:** when `mult_rdy`=1, pulse `mult_start` and go to WAIT_RES.
- **WAIT_RES:**
  - When `acc_out_rdy`=1, pulse `acc_out_pop`.
  - Same cycle: accumulator ← (accum ? acc + `acc_out` : `acc_out`), then decrement `k_rem`.
  - Next state:
    - not accum → OUT;
    - accum and `k_rem`>1 → LOAD;
    - accum and `k_rem`=1 → OUT.
- **OUT:**
  - `res_valid`=1, `res_out`=accumulator; both are stable until `res_rdy`.
  - On `res_valid && res_rdy`:
    - `k_rem`=0 → IDLE;
    - otherwise (non-accum mode) → LOAD.
- Arithmetic: per-element signed ACC_W add. Overflow handling is set by the configuration macro.
- `mult_done` is not required for sequencing; it is available for debug/assertions only.

## Timing
- Reset: all outputs 0, state IDLE, accumulators 0, `k_rem` 0. `cmd_rdy` goes to 1 on the first clock after `rst` deasserts.
- Reset mid-command: abort immediately. The mmu must be reset together with this block; no pending handshake is completed.
- Pulses (`weight_ld_start`, `weight_swap`, `mult_start`, `acc_out_pop`) are exactly one cycle and registered.
- Minimum overhead per tile, excluding mmu latency, with all ready/done inputs already high:
  - LOAD 1 + WAIT_LD 1 + SWAP 1 + MULT 1 + WAIT_RES 1 = 5 cycles.
  - OUT adds 1 cycle when `res_rdy` is held high.
- `cmd_valid` while busy: ignored and not lost; the command is held by the producer until `cmd_rdy`.
- `cmd_k`=`MAX_K`: legal, `k_rem` does not overflow. `cmd_k`>`MAX_K` is a protocol error: set `err` and refuse the command as for `cmd_k`=0.

## Configuration
- `MMU_SEQ_SAT_EN` defined:
  - accumulation saturates each element to [−2^(ACC_W−1), 2^(ACC_W−1)−1];
  - any saturation sets `err`.
- Undefined: two's-complement wrap, and `err` is set only for command errors.

## Structure
- `mmu_pkg`: state enum `mmu_seq_state_e`, default `ACC_W`, and a function `sat_add(a, b)`.
- Sub-module `mmu_acc_bank`:
  - SIZE×SIZE register array with clear, load, and add-or-load controls;
  - per-element adder;
  - OR-reduced saturation flag.
- The FSM, `k_rem` counter and handshake pulses live in `mmu_tile_seq`.

## Test plan
- Non-accum, `cmd_k`=1, `acc_out` all 5 → one result all 5; `busy` high ≥5 cycles; `cmd_rdy` back to 1.
- Accum, `cmd_k`=3, tiles 1/2/3 → single result all 6; exactly 3 each of `weight_ld_start` / `weight_swap` / `mult_start` / `acc_out_pop`.
- Non-accum, `cmd_k`=2, `res_rdy` held 0 for 10 cycles → first result stable throughout; second tile's LOAD starts only after handshake.
- `cmd_k`=0 → `err`=1, no mmu pulses, state stays IDLE; next valid command clears `err`.
- With `MMU_SEQ_SAT_EN`, ACC_W=32: accumulate 0x7FFFFFF0 + 0x20 → 0x7FFFFFFF, `err`=1. Without the macro → 0x80000010, `err`=0.
- Assert `rst` during WAIT_RES → all outputs 0 next edge; new command after release runs normally.
